// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement stage with CDB capture, operand query and branch rollback.
// Optional define ROB_CDB_BYPASS_EN lets operand queries also match the current-cycle CDB broadcast.
module reorder_buffer #(
  parameter int ROB_SIZE = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        alloc_flag_from_dispatcher,
  input  logic [4:0]  rd_from_dispatcher,
  input  logic        is_branch_from_dispatcher,
  input  logic        pred_jump_from_dispatcher,
  output logic        full_to_dispatcher,
  output logic [4:0]  tag_to_dispatcher,
  input  logic [4:0]  Q1_from_dispatcher,
  input  logic [4:0]  Q2_from_dispatcher,
  output logic        ready1_to_dispatcher,
  output logic        ready2_to_dispatcher,
  output logic [31:0] V1_to_dispatcher,
  output logic [31:0] V2_to_dispatcher,
  input  logic        cdb_flag,
  input  logic [4:0]  cdb_Q,
  input  logic [31:0] cdb_V,
  input  logic        cdb_jump,
  input  logic [31:0] cdb_pc,
  output logic        commit_flag_to_regfile,
  output logic [4:0]  rd_to_regfile,
  output logic [4:0]  Q_to_regfile,
  output logic [31:0] V_to_regfile,
  output logic        rollback_flag_to_regfile,
  output logic [31:0] jump_pc_to_fetcher
);
  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = $clog2(ROB_SIZE + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic        is_branch;
    logic        pred_jump;
    logic [31:0] v;
    logic        real_jump;
    logic [31:0] pc;
  } entry_t;

  typedef struct packed {
    logic        rdy;
    logic [31:0] v;
  } query_t;

  entry_t              entries [ROB_SIZE];
  logic [ROB_SIZE-1:0] valid;
  logic [ROB_SIZE-1:0] ready;
  logic [IDX_W-1:0]    head;
  logic [IDX_W-1:0]    tail;
  logic [CNT_W-1:0]    count;

  logic             full;
  logic             do_commit;
  logic             mispredict;
  logic             do_alloc;
  logic             do_wb;
  logic [IDX_W-1:0] wb_idx;
  entry_t           head_entry;
  query_t           q1_res;
  query_t           q2_res;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(ROB_SIZE - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  assign full               = (count == CNT_W'(ROB_SIZE));
  assign full_to_dispatcher = full;
  assign tag_to_dispatcher  = 5'(tail) + 5'd1;
  assign head_entry         = entries[head];
  assign wb_idx             = IDX_W'(cdb_Q - 5'd1);

  // The cycle in which rollback is visible belongs to the flushed stream: no commit, alloc or capture.
  assign do_commit  = rdy_in && !rollback_flag_to_regfile && valid[head] && ready[head];
  assign mispredict = do_commit && head_entry.is_branch
                      && (head_entry.real_jump != head_entry.pred_jump);
  assign do_alloc   = rdy_in && !rollback_flag_to_regfile && !mispredict
                      && alloc_flag_from_dispatcher && !full;
  assign do_wb      = rdy_in && !rollback_flag_to_regfile && !mispredict && cdb_flag
                      && (cdb_Q != 5'd0) && (cdb_Q <= 5'(ROB_SIZE));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (mispredict) begin
      valid <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_commit) begin
        valid[head] <= 1'b0;
        ready[head] <= 1'b0;
        head        <= wrap_inc(head);
      end
      if (do_wb) ready[wb_idx] <= 1'b1;
      if (do_alloc) begin
        valid[tail] <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= wrap_inc(tail);
      end
      count <= count + CNT_W'(do_alloc) - CNT_W'(do_commit);
    end
  end

  // NOTE: entry payload has no reset; valid/ready qualify every read, so stale data is never observed.
  always_ff @(posedge clk_in) begin
    if (do_alloc) begin
      entries[tail] <= '{rd: rd_from_dispatcher, is_branch: is_branch_from_dispatcher,
                         pred_jump: pred_jump_from_dispatcher, v: 32'h0, real_jump: 1'b0,
                         pc: 32'h0};
    end
    if (do_wb) begin
      entries[wb_idx].v         <= cdb_V;
      entries[wb_idx].real_jump <= cdb_jump;
      entries[wb_idx].pc        <= cdb_pc;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      commit_flag_to_regfile   <= 1'b0;
      rd_to_regfile            <= '0;
      Q_to_regfile             <= '0;
      V_to_regfile             <= '0;
      rollback_flag_to_regfile <= 1'b0;
      jump_pc_to_fetcher       <= '0;
    end else begin
      commit_flag_to_regfile   <= do_commit;
      rd_to_regfile            <= do_commit ? head_entry.rd : 5'd0;
      Q_to_regfile             <= do_commit ? 5'(head) + 5'd1 : 5'd0;
      V_to_regfile             <= do_commit ? head_entry.v : 32'h0;
      rollback_flag_to_regfile <= mispredict;
      jump_pc_to_fetcher       <= mispredict ? head_entry.pc : 32'h0;
    end
  end

  function automatic query_t lookup(input logic [4:0] q);
    logic [IDX_W-1:0] idx;
    lookup = '0;
    idx    = IDX_W'(q - 5'd1);
    if ((q != 5'd0) && (q <= 5'(ROB_SIZE)) && valid[idx] && ready[idx]) begin
      lookup.rdy = 1'b1;
      lookup.v   = entries[idx].v;
    end
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_flag && (q != 5'd0) && (cdb_Q == q)) begin
      lookup.rdy = 1'b1;
      lookup.v   = cdb_V;
    end
`endif
  endfunction

  // NOTE: every always_comb output is assigned on all paths (lookup starts from '0), so no latch.
  always_comb begin
    q1_res = lookup(Q1_from_dispatcher);
    q2_res = lookup(Q2_from_dispatcher);
  end

  assign ready1_to_dispatcher = q1_res.rdy;
  assign V1_to_dispatcher     = q1_res.v;
  assign ready2_to_dispatcher = q2_res.rdy;
  assign V2_to_dispatcher     = q2_res.v;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_reorder_buffer;
  localparam int N = 16;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        alloc_flag_from_dispatcher;
  logic [4:0]  rd_from_dispatcher;
  logic        is_branch_from_dispatcher, pred_jump_from_dispatcher;
  logic        full_to_dispatcher;
  logic [4:0]  tag_to_dispatcher;
  logic [4:0]  Q1_from_dispatcher, Q2_from_dispatcher;
  logic        ready1_to_dispatcher, ready2_to_dispatcher;
  logic [31:0] V1_to_dispatcher, V2_to_dispatcher;
  logic        cdb_flag;
  logic [4:0]  cdb_Q;
  logic [31:0] cdb_V;
  logic        cdb_jump;
  logic [31:0] cdb_pc;
  logic        commit_flag_to_regfile;
  logic [4:0]  rd_to_regfile, Q_to_regfile;
  logic [31:0] V_to_regfile;
  logic        rollback_flag_to_regfile;
  logic [31:0] jump_pc_to_fetcher;

  always #5 clk_in = ~clk_in;

  reorder_buffer #(.ROB_SIZE(N)) dut (
    .clk_in                     (clk_in),
    .rst_in                     (rst_in),
    .rdy_in                     (rdy_in),
    .alloc_flag_from_dispatcher (alloc_flag_from_dispatcher),
    .rd_from_dispatcher         (rd_from_dispatcher),
    .is_branch_from_dispatcher  (is_branch_from_dispatcher),
    .pred_jump_from_dispatcher  (pred_jump_from_dispatcher),
    .full_to_dispatcher         (full_to_dispatcher),
    .tag_to_dispatcher          (tag_to_dispatcher),
    .Q1_from_dispatcher         (Q1_from_dispatcher),
    .Q2_from_dispatcher         (Q2_from_dispatcher),
    .ready1_to_dispatcher       (ready1_to_dispatcher),
    .ready2_to_dispatcher       (ready2_to_dispatcher),
    .V1_to_dispatcher           (V1_to_dispatcher),
    .V2_to_dispatcher           (V2_to_dispatcher),
    .cdb_flag                   (cdb_flag),
    .cdb_Q                      (cdb_Q),
    .cdb_V                      (cdb_V),
    .cdb_jump                   (cdb_jump),
    .cdb_pc                     (cdb_pc),
    .commit_flag_to_regfile     (commit_flag_to_regfile),
    .rd_to_regfile              (rd_to_regfile),
    .Q_to_regfile               (Q_to_regfile),
    .V_to_regfile               (V_to_regfile),
    .rollback_flag_to_regfile   (rollback_flag_to_regfile),
    .jump_pc_to_fetcher         (jump_pc_to_fetcher)
  );

  // Reference model: in-flight instructions in program order, each remembering its tag.
  typedef struct {
    int          tag;
    logic [4:0]  rd;
    bit          br;
    bit          pj;
    bit          done;
    logic [31:0] v;
    bit          jmp;
    logic [31:0] pc;
  } m_ent_t;

  m_ent_t      mq[$];
  int          next_tag;
  bit          e_commit, e_rb;
  logic [4:0]  e_rd, e_q;
  logic [31:0] e_v, e_pc;
  int          total = 0;
  int          bad = 0;

  task automatic model_reset();
    mq.delete();
    next_tag = 1;
    e_commit = 0; e_rb = 0; e_rd = '0; e_q = '0; e_v = '0; e_pc = '0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit     old_rb, commit, misp, accept;
    m_ent_t h;
    old_rb = e_rb;
    commit = rdy_in && !old_rb && (mq.size() > 0) && mq[0].done;
    if (commit) h = mq[0];
    misp   = commit && h.br && (h.jmp != h.pj);
    accept = rdy_in && !old_rb && alloc_flag_from_dispatcher && (mq.size() < N);
    e_commit = commit;
    e_rd     = commit ? h.rd : 5'd0;
    e_q      = commit ? 5'(h.tag) : 5'd0;
    e_v      = commit ? h.v : 32'h0;
    e_rb     = misp;
    e_pc     = misp ? h.pc : 32'h0;
    if (misp) begin
      mq.delete();
      next_tag = 1;
      return;
    end
    if (rdy_in && !old_rb && cdb_flag && cdb_Q != 5'd0)
      foreach (mq[i])
        if (mq[i].tag == int'(cdb_Q)) begin
          mq[i].done = 1; mq[i].v = cdb_V; mq[i].jmp = cdb_jump; mq[i].pc = cdb_pc;
        end
    if (commit) void'(mq.pop_front());
    if (accept) begin
      mq.push_back('{tag: next_tag, rd: rd_from_dispatcher, br: is_branch_from_dispatcher,
                     pj: pred_jump_from_dispatcher, done: 0, v: 32'h0, jmp: 0, pc: 32'h0});
      next_tag = (next_tag == N) ? 1 : next_tag + 1;
    end
  endtask

  function automatic logic [32:0] model_query(input logic [4:0] q);
    model_query = '0;
    if (q != 5'd0)
      foreach (mq[i])
        if (mq[i].tag == int'(q) && mq[i].done) model_query = {1'b1, mq[i].v};
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_flag && q != 5'd0 && cdb_Q == q) model_query = {1'b1, cdb_V};
`endif
  endfunction

  task automatic idle_inputs();
    alloc_flag_from_dispatcher = 0; rd_from_dispatcher = '0;
    is_branch_from_dispatcher = 0; pred_jump_from_dispatcher = 0;
    cdb_flag = 0; cdb_Q = '0; cdb_V = '0; cdb_jump = 0; cdb_pc = '0;
    Q1_from_dispatcher = '0; Q2_from_dispatcher = '0;
  endtask

  task automatic drive_alloc(input logic [4:0] rd, input bit br, input bit pj);
    alloc_flag_from_dispatcher = 1; rd_from_dispatcher = rd;
    is_branch_from_dispatcher = br; pred_jump_from_dispatcher = pj;
  endtask

  task automatic drive_cdb(input logic [4:0] q, input logic [31:0] v, input bit j, input logic [31:0] pc);
    cdb_flag = 1; cdb_Q = q; cdb_V = v; cdb_jump = j; cdb_pc = pc;
  endtask

  // One clock: update the model, cross the edge, settle, then release the inputs.
  task automatic tick();
    model_edge();
    @(posedge clk_in);
    #1;
    idle_inputs();
  endtask

  task automatic apply_reset();
    rst_in = 0; rdy_in = 1;
    idle_inputs();
    model_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1;
  endtask

  task automatic test_reset();
    rst_in = 0; rdy_in = 1;
    idle_inputs();
    model_reset();
    #1;
    total++;
    if ({commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile,
         rollback_flag_to_regfile, jump_pc_to_fetcher} !== 76'h0) begin
      bad++; $display("FAIL reset_outputs: got commit=%b rd=%0d Q=%0d V=%h rb=%b pc=%h want all 0",
                      commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile,
                      rollback_flag_to_regfile, jump_pc_to_fetcher);
    end
    total++;
    if (full_to_dispatcher !== 1'b0 || tag_to_dispatcher !== 5'd1) begin
      bad++; $display("FAIL reset_full_tag: got full=%b tag=%0d want full=0 tag=1",
                      full_to_dispatcher, tag_to_dispatcher);
    end
    total++;
    if (ready1_to_dispatcher !== 1'b0 || V1_to_dispatcher !== 32'h0) begin
      bad++; $display("FAIL reset_query0: got ready=%b V=%h want 0/0", ready1_to_dispatcher, V1_to_dispatcher);
    end
    @(posedge clk_in);
    #1;
    rst_in = 1;
  endtask

  task automatic test_in_order_commit();
    logic [4:0] rds[3] = '{5'd5, 5'd6, 5'd7};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (tag_to_dispatcher !== 5'(i + 1)) begin
        bad++; $display("FAIL alloc_tag_%0d: got %0d want %0d", i, tag_to_dispatcher, i + 1);
      end
      drive_alloc(rds[i], 0, 0);
      tick();
    end
    drive_cdb(5'd2, 32'h22, 0, 32'h0);
    tick();
    drive_cdb(5'd1, 32'h11, 0, 32'h0);
    tick();
    total++;
    if (commit_flag_to_regfile !== 1'b0) begin
      bad++; $display("FAIL commit_same_edge_as_cdb: got commit=%b want 0", commit_flag_to_regfile);
    end
    tick();
    total++;
    if ({commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile} !== {1'b1, 5'd5, 5'd1, 32'h11}) begin
      bad++; $display("FAIL first_commit: got commit=%b rd=%0d Q=%0d V=%h want 1/5/1/11",
                      commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile);
    end
    tick();
    total++;
    if ({commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile} !== {1'b1, 5'd6, 5'd2, 32'h22}) begin
      bad++; $display("FAIL second_commit: got commit=%b rd=%0d Q=%0d V=%h want 1/6/2/22",
                      commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile);
    end
    tick();
    total++;
    if (commit_flag_to_regfile !== 1'b0) begin
      bad++; $display("FAIL no_commit_unready: got commit=%b want 0", commit_flag_to_regfile);
    end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < N; i++) begin
      drive_alloc(5'(i + 1), 0, 0);
      tick();
    end
    total++;
    if (full_to_dispatcher !== 1'b1 || tag_to_dispatcher !== 5'd1) begin
      bad++; $display("FAIL full_after_fill: got full=%b tag=%0d want 1/1", full_to_dispatcher, tag_to_dispatcher);
    end
    drive_alloc(5'd31, 0, 0);
    tick();
    total++;
    if (full_to_dispatcher !== 1'b1 || tag_to_dispatcher !== 5'd1) begin
      bad++; $display("FAIL alloc_when_full: got full=%b tag=%0d want 1/1", full_to_dispatcher, tag_to_dispatcher);
    end
    drive_cdb(5'd1, 32'hAA, 0, 32'h0);
    tick();
    drive_alloc(5'd30, 0, 0);
    tick();
    total++;
    if ({commit_flag_to_regfile, Q_to_regfile, full_to_dispatcher, tag_to_dispatcher} !==
        {1'b1, 5'd1, 1'b0, 5'd1}) begin
      bad++; $display("FAIL commit_frees_slot: got commit=%b Q=%0d full=%b tag=%0d want 1/1/0/1",
                      commit_flag_to_regfile, Q_to_regfile, full_to_dispatcher, tag_to_dispatcher);
    end
    drive_alloc(5'd29, 0, 0);
    tick();
    total++;
    if (full_to_dispatcher !== 1'b1 || tag_to_dispatcher !== 5'd2) begin
      bad++; $display("FAIL alloc_after_wrap: got full=%b tag=%0d want 1/2", full_to_dispatcher, tag_to_dispatcher);
    end
  endtask

  task automatic test_rollback();
    apply_reset();
    drive_alloc(5'd0, 1, 0);
    tick();
    drive_alloc(5'd3, 0, 0);
    tick();
    drive_cdb(5'd2, 32'h5, 0, 32'h0);
    tick();
    drive_cdb(5'd1, 32'h0, 1, 32'h100);
    tick();
    tick();
    total++;
    if ({commit_flag_to_regfile, Q_to_regfile, rollback_flag_to_regfile, jump_pc_to_fetcher} !==
        {1'b1, 5'd1, 1'b1, 32'h100}) begin
      bad++; $display("FAIL rollback_pulse: got commit=%b Q=%0d rb=%b pc=%h want 1/1/1/100",
                      commit_flag_to_regfile, Q_to_regfile, rollback_flag_to_regfile, jump_pc_to_fetcher);
    end
    drive_alloc(5'd9, 0, 0);
    tick();
    total++;
    if ({rollback_flag_to_regfile, commit_flag_to_regfile, jump_pc_to_fetcher} !== {1'b0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL rollback_one_cycle: got rb=%b commit=%b pc=%h want 0/0/0",
                      rollback_flag_to_regfile, commit_flag_to_regfile, jump_pc_to_fetcher);
    end
    total++;
    if (tag_to_dispatcher !== 5'd1 || full_to_dispatcher !== 1'b0) begin
      bad++; $display("FAIL rollback_clears: got tag=%0d full=%b want 1/0", tag_to_dispatcher, full_to_dispatcher);
    end
    Q1_from_dispatcher = 5'd2;
    #1;
    total++;
    if (ready1_to_dispatcher !== 1'b0) begin
      bad++; $display("FAIL flushed_query: got ready=%b want 0", ready1_to_dispatcher);
    end
    tick();
    total++;
    if (commit_flag_to_regfile !== 1'b0) begin
      bad++; $display("FAIL flushed_commit: got commit=%b want 0", commit_flag_to_regfile);
    end
  endtask

  task automatic test_query_bypass();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_alloc(5'(i + 1), 0, 0);
      tick();
    end
    Q1_from_dispatcher = 5'd4;
    drive_cdb(5'd4, 32'hABCD, 0, 32'h0);
    #1;
    total++;
`ifdef ROB_CDB_BYPASS_EN
    if (ready1_to_dispatcher !== 1'b1 || V1_to_dispatcher !== 32'hABCD) begin
      bad++; $display("FAIL query_same_cycle: got ready=%b V=%h want 1/abcd", ready1_to_dispatcher, V1_to_dispatcher);
    end
`else
    if (ready1_to_dispatcher !== 1'b0 || V1_to_dispatcher !== 32'h0) begin
      bad++; $display("FAIL query_same_cycle: got ready=%b V=%h want 0/0", ready1_to_dispatcher, V1_to_dispatcher);
    end
`endif
    tick();
    Q1_from_dispatcher = 5'd4;
    Q2_from_dispatcher = 5'd0;
    #1;
    total++;
    if ({ready1_to_dispatcher, V1_to_dispatcher, ready2_to_dispatcher, V2_to_dispatcher} !==
        {1'b1, 32'hABCD, 1'b0, 32'h0}) begin
      bad++; $display("FAIL query_next_cycle: got r1=%b V1=%h r2=%b V2=%h want 1/abcd/0/0",
                      ready1_to_dispatcher, V1_to_dispatcher, ready2_to_dispatcher, V2_to_dispatcher);
    end
    idle_inputs();
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_alloc(5'(10 + i), 0, 0);
      tick();
    end
    drive_cdb(5'd1, 32'h1, 0, 32'h0);
    tick();
    drive_cdb(5'd2, 32'h2, 0, 32'h0);
    tick();
    total++;
    if (commit_flag_to_regfile !== 1'b1 || Q_to_regfile !== 5'd1) begin
      bad++; $display("FAIL midreset_precommit: got commit=%b Q=%0d want 1/1", commit_flag_to_regfile, Q_to_regfile);
    end
    #2;
    rst_in = 0;
    #1;
    total++;
    if ({commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile, rollback_flag_to_regfile,
         jump_pc_to_fetcher, full_to_dispatcher, tag_to_dispatcher} !== {76'h0, 1'b0, 5'd1}) begin
      bad++; $display("FAIL midreset_immediate: got commit=%b rd=%0d Q=%0d V=%h tag=%0d want 0s and tag 1",
                      commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile, tag_to_dispatcher);
    end
    model_reset();
    @(negedge clk_in);
    rst_in = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (commit_flag_to_regfile !== 1'b0) begin
        bad++; $display("FAIL midreset_no_commit_%0d: got commit=%b want 0", i, commit_flag_to_regfile);
      end
    end
  endtask

  task automatic test_rdy_hold();
    apply_reset();
    drive_alloc(5'd7, 0, 0);
    tick();
    drive_cdb(5'd1, 32'h77, 0, 32'h0);
    tick();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      drive_alloc(5'd8, 0, 0);
      tick();
      total++;
      if (commit_flag_to_regfile !== 1'b0 || tag_to_dispatcher !== 5'd2) begin
        bad++; $display("FAIL rdy_low_hold_%0d: got commit=%b tag=%0d want 0/2", i, commit_flag_to_regfile, tag_to_dispatcher);
      end
    end
    rdy_in = 1;
    tick();
    total++;
    if ({commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile} !== {1'b1, 5'd7, 5'd1, 32'h77}) begin
      bad++; $display("FAIL rdy_release_commit: got commit=%b rd=%0d Q=%0d V=%h want 1/7/1/77",
                      commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile);
    end
  endtask

  task automatic test_random();
    int          pend[$];
    logic [75:0] act_r, exp_r;
    logic [71:0] act_c, exp_c;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) != 0)
        drive_alloc(5'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
      pend.delete();
      foreach (mq[i]) if (!mq[i].done) pend.push_back(mq[i].tag);
      if (rdy_in && pend.size() > 0 && $urandom_range(0, 2) != 0)
        drive_cdb(5'(pend[$urandom_range(0, pend.size() - 1)]), $urandom, 1'($urandom), $urandom);
      Q1_from_dispatcher = 5'($urandom_range(0, N));
      Q2_from_dispatcher = cdb_flag ? cdb_Q : 5'($urandom_range(0, N));
      #1;
      act_c = {full_to_dispatcher, tag_to_dispatcher, ready1_to_dispatcher, V1_to_dispatcher,
               ready2_to_dispatcher, V2_to_dispatcher};
      exp_c = {(mq.size() == N), 5'(next_tag), model_query(Q1_from_dispatcher), model_query(Q2_from_dispatcher)};
      total++;
      if (act_c !== exp_c) begin
        bad++; $display("FAIL random_comb cycle %0d: got %h want %h", c, act_c, exp_c);
      end
      tick();
      act_r = {commit_flag_to_regfile, rd_to_regfile, Q_to_regfile, V_to_regfile,
               rollback_flag_to_regfile, jump_pc_to_fetcher};
      exp_r = {e_commit, e_rd, e_q, e_v, e_rb, e_pc};
      total++;
      if (act_r !== exp_r) begin
        bad++; $display("FAIL random_regs cycle %0d: got %h want %h", c, act_r, exp_r);
      end
    end
    rdy_in = 1;
  endtask

  initial begin
    test_reset();
    test_in_order_commit();
    test_full_wrap();
    test_rollback();
    test_query_bypass();
    test_reset_midstream();
    test_rdy_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
